// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: BLOCK-bit lookahead groups, carries ripple
// between groups, and the group chain is cut into STAGES equal register slices.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int G = WIDTH / BLOCK / STAGES;

  typedef struct packed {
    logic [BLOCK-1:0] sum;
    logic             co;
    logic             cm;
  } grp_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             c;
    logic             ovf;
    logic             z;
  } stg_t;

  // Every carry inside a group is a flat sum of products of g/p and the group carry-in.
  function automatic grp_t cla_grp(input logic [BLOCK-1:0] ga, input logic [BLOCK-1:0] gb,
                                   input logic cin);
    grp_t             r;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             term;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i];
      term   = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = c[i+1] | term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    r.sum = p ^ c[BLOCK-1:0];
    r.co  = c[BLOCK];
    r.cm  = c[BLOCK-1];
    return r;
  endfunction

  // Resolves the G groups owned by slice s; ovf/z are only meaningful in the final slice.
  function automatic stg_t slice_f(input stg_t x, input int s);
    stg_t y;
    grp_t r;
    int   base;
    y = x;
    for (int g = 0; g < G; g++) begin
      base  = (s * G + g) * BLOCK;
      r     = cla_grp(x.opa[base +: BLOCK], x.opb[base +: BLOCK], y.c);
      y.res[base +: BLOCK] = r.sum;
      y.c   = r.co;
      y.ovf = r.co ^ r.cm;
    end
    y.z = (y.res == '0);
    return y;
  endfunction

  logic adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stg_t stg_in;
    stg_t stg_d;
    stg_t stg_q;
    logic vld_q;

    if (s == 0) begin : g_head
      assign stg_in = '{res: '0, opa: a, opb: b ^ {WIDTH{sub}}, c: sub, ovf: 1'b0, z: 1'b0};
      always_ff @(posedge clk) begin
        if (reset)    vld_q <= 1'b0;
        else if (adv) vld_q <= in_valid;
      end
    end else begin : g_body
      assign stg_in = g_stage[s-1].stg_q;
      always_ff @(posedge clk) begin
        if (reset)    vld_q <= 1'b0;
        else if (adv) vld_q <= g_stage[s-1].vld_q;
      end
    end

    assign stg_d = slice_f(stg_in, s);

    // The last slice drives the outputs directly, so it alone clears its data on reset.
    if (s == STAGES - 1) begin : g_out
      always_ff @(posedge clk) begin
        if (reset)    stg_q <= '0;
        else if (adv) stg_q <= stg_d;
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (adv) stg_q <= stg_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign result    = g_stage[STAGES-1].stg_q.res;
  assign cout      = g_stage[STAGES-1].stg_q.c;
  assign overflow  = g_stage[STAGES-1].stg_q.ovf;
  assign zero      = g_stage[STAGES-1].stg_q.z;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: three instances (STAGES = 2, 1, 8) driven by directed
// vectors, with a negedge monitor that scores every output transfer against a model.
module tb_cla_addsub_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid_s [3];
  logic         in_ready_s [3];
  logic         sub_s      [3];
  logic         out_valid_s[3];
  logic         out_ready_s[3];
  logic         cout_s     [3];
  logic         ovf_s      [3];
  logic         zero_s     [3];
  logic [W-1:0] a_s        [3];
  logic [W-1:0] b_s        [3];
  logic [W-1:0] result_s   [3];

  int stg_of[3] = '{2, 1, 8};

  cla_addsub_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(2)) u_s2 (
    .clk(clk), .reset(reset), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]), .sub(sub_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .result(result_s[0]), .cout(cout_s[0]),
    .overflow(ovf_s[0]), .zero(zero_s[0]));

  cla_addsub_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]), .sub(sub_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .result(result_s[1]), .cout(cout_s[1]),
    .overflow(ovf_s[1]), .zero(zero_s[1]));

  cla_addsub_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(8)) u_s8 (
    .clk(clk), .reset(reset), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .a(a_s[2]), .b(b_s[2]), .sub(sub_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .result(result_s[2]), .cout(cout_s[2]),
    .overflow(ovf_s[2]), .zero(zero_s[2]));

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[8];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_in [3];
  int   n_out[3];
  exp_t expq [3][$];

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        m;
    logic [32:0] t;
    logic [31:0] bb;
    bb  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    m.r = t[31:0];
    m.c = t[32];
    m.v = s ? ((a[31] != b[31]) && (t[31] != a[31])) : ((a[31] == b[31]) && (t[31] != a[31]));
    m.z = (t[31:0] == 32'd0);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic setv(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] r, input logic c, input logic v, input logic z);
    vecs[i] = '{a: a, b: b, sub: s, r: r, c: c, v: v, z: z};
  endtask

  // Presents one op on instance k and holds it until accepted.
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    bit acc;
    a_s[k] = a; b_s[k] = b; sub_s[k] = s; in_valid_s[k] = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready_s[k];
      @(posedge clk); #1;
      n++;
    end
    in_valid_s[k] = 1'b0;
    chk($sformatf("accept%0d", k), {63'd0, acc}, 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        expq[k].delete();
        n_in[k] = 0;
        n_out[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid_s[k] && out_ready_s[k]) begin
          n_out[k]++;
          if (expq[k].size() == 0) begin
            n_chk++;
            $display("FAIL mon%0d unexpected output: result=%h, expected no pending op", k,
                     result_s[k]);
          end else begin
            e = expq[k].pop_front();
            chk($sformatf("mon%0d {result,cout,ovf,zero}", k),
                {29'd0, result_s[k], cout_s[k], ovf_s[k], zero_s[k]},
                {29'd0, e.r, e.c, e.v, e.z});
          end
        end
        if (in_valid_s[k] && in_ready_s[k]) begin
          expq[k].push_back(model(a_s[k], b_s[k], sub_s[k]));
          n_in[k]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int lat;
    int first[3];
    int last [3];
    int cnt  [3];
    int in0, out0, w;
    logic [31:0] held_r;
    logic        held_c, held_v, held_z;

    setv(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    setv(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    setv(2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    setv(3, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    setv(4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    setv(5, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    setv(6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
    setv(7, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1; sub_s[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("post-reset out_valid", {63'd0, out_valid_s[0]}, 64'd0);
    chk("post-reset in_ready", {63'd0, in_ready_s[0]}, 64'd1);

    // Directed vectors on the STAGES=2 instance, one op at a time.
    for (int i = 0; i < 8; i++) begin
      a_s[0] = vecs[i].a; b_s[0] = vecs[i].b; sub_s[0] = vecs[i].sub; in_valid_s[0] = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready_s[0]}, 64'd1);
      @(posedge clk); #1;
      in_valid_s[0] = 1'b0;
      lat = 1;
      while (!out_valid_s[0] && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d result", i), {32'd0, result_s[0]}, {32'd0, vecs[i].r});
      chk($sformatf("vec%0d cout", i), {63'd0, cout_s[0]}, {63'd0, vecs[i].c});
      chk($sformatf("vec%0d overflow", i), {63'd0, ovf_s[0]}, {63'd0, vecs[i].v});
      chk($sformatf("vec%0d zero", i), {63'd0, zero_s[0]}, {63'd0, vecs[i].z});
      @(posedge clk); #1;
    end

    // Reset in the middle of a running stream; in_valid stays high through reset.
    for (int k = 0; k < 3; k++) begin
      a_s[k] = 32'h0000_0005; b_s[k] = 32'h0000_0003; sub_s[k] = 1'b0; in_valid_s[k] = 1'b1;
    end
    repeat (10) begin @(posedge clk); #1; end
    for (int k = 0; k < 3; k++)
      chk($sformatf("pre-reset result%0d", k), {32'd0, result_s[k]}, 64'd8);
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k] = 1'b0;
      chk($sformatf("rst%0d out_valid", k), {63'd0, out_valid_s[k]}, 64'd0);
      chk($sformatf("rst%0d result", k), {32'd0, result_s[k]}, 64'd0);
      chk($sformatf("rst%0d flags", k), {61'd0, cout_s[k], ovf_s[k], zero_s[k]}, 64'd0);
      chk($sformatf("rst%0d in_ready", k), {63'd0, in_ready_s[k]}, 64'd1);
    end
    repeat (10) begin @(posedge clk); #1; end
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst%0d no ghost op", k), {63'd0, out_valid_s[k]}, 64'd0);

    // Back-to-back stream of 8 mixed ops into all instances, out_ready held high.
    for (int k = 0; k < 3; k++) begin
      first[k] = -1; last[k] = -1; cnt[k] = 0;
    end
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid_s[k]) begin
          if (first[k] < 0) first[k] = t;
          last[k] = t;
          cnt[k]++;
        end
        if (t < 8) begin
          a_s[k] = vecs[t].a; b_s[k] = vecs[t].b; sub_s[k] = vecs[t].sub; in_valid_s[k] = 1'b1;
        end else begin
          in_valid_s[k] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stream%0d first output cycle", k), 64'(first[k]), 64'(stg_of[k]));
      chk($sformatf("stream%0d output count", k), 64'(cnt[k]), 64'd8);
      chk($sformatf("stream%0d contiguous span", k), 64'(last[k] - first[k] + 1), 64'd8);
      chk($sformatf("stream%0d ops in", k), 64'(n_in[k]), 64'd8);
      chk($sformatf("stream%0d ops out", k), 64'(n_out[k]), 64'd8);
    end

    // Backpressure with the pipe full, per instance.
    for (int k = 0; k < 3; k++) begin
      in0 = n_in[k]; out0 = n_out[k];
      fork
        begin
          for (int j = 0; j < stg_of[k] + 4; j++)
            send(k, vecs[j % 8].a, vecs[j % 8].b, vecs[j % 8].sub);
        end
        begin
          out_ready_s[k] = 1'b0;
          w = 0;
          while (!out_valid_s[k] && w < 40) begin
            @(posedge clk); #1;
            w++;
          end
          chk($sformatf("bp%0d pipe filled", k), {63'd0, out_valid_s[k]}, 64'd1);
          held_r = result_s[k]; held_c = cout_s[k]; held_v = ovf_s[k]; held_z = zero_s[k];
          chk($sformatf("bp%0d head result", k), {32'd0, held_r}, {32'd0, vecs[0].r});
          repeat (3) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d held out_valid", k), {63'd0, out_valid_s[k]}, 64'd1);
            chk($sformatf("bp%0d held result/flags", k),
                {29'd0, result_s[k], cout_s[k], ovf_s[k], zero_s[k]},
                {29'd0, held_r, held_c, held_v, held_z});
            chk($sformatf("bp%0d in_ready low", k), {63'd0, in_ready_s[k]}, 64'd0);
          end
          out_ready_s[k] = 1'b1;
        end
      join
      repeat (stg_of[k] + 3) begin @(posedge clk); #1; end
      chk($sformatf("bp%0d ops in", k), 64'(n_in[k] - in0), 64'(stg_of[k] + 4));
      chk($sformatf("bp%0d ops out", k), 64'(n_out[k] - out0), 64'(stg_of[k] + 4));
      chk($sformatf("bp%0d scoreboard drained", k), 64'(expq[k].size()), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
